// File: rtl/cla28_arb.sv
// Round-robin scheduler sharing one carry-lookahead add/sub datapath (cla28)
// among NREQ requesters; results return tagged with the requester index.

module cla28 #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);
    localparam int W  = WIDTH + 1;
    localparam int GW = 4;
    localparam int NG = (W + GW - 1) / GW;

    // Group carries are looked ahead from generate/propagate terms; bits inside
    // a group derive their carry from that group's carry-in. Subtract is
    // A + ~B + 1, with the +1 entering as the carry into bit 0.
    always_comb begin : adder
        logic [W-1:0]  bx;
        logic [W-1:0]  p;
        logic [W-1:0]  cy;
        logic [W-2:0]  g;
        logic [NG-1:0] gcy;
        bx     = b ^ {W{sub}};
        p      = a ^ bx;
        g      = a[W-2:0] & bx[W-2:0];
        cy     = '0;
        gcy    = '0;
        gcy[0] = sub;
        for (int k = 0; k < NG; k++) begin
            for (int j = k * GW; j < (k + 1) * GW && j < W; j++) begin
                cy[j] = gcy[k];
                for (int m = k * GW; m < j; m++) begin
                    cy[j] = g[m] | (p[m] & cy[j]);
                end
            end
            if (k < NG - 1) begin
                gcy[k+1] = gcy[k];
                for (int m = k * GW; m < (k + 1) * GW; m++) begin
                    gcy[k+1] = g[m] | (p[m] & gcy[k+1]);
                end
            end
        end
        sum = p ^ cy;
    end

endmodule

module cla28_arb #(
    parameter int WIDTH = 27,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_sub,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [WIDTH:0]            rsp_data,
    output logic                      busy
);
    localparam int W = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [IDW-1:0] last_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] id_q;
    logic           found;
    logic           grant;
    logic [W-1:0]   a_sel, b_sel;
    logic [W-1:0]   a_q, b_q;
    logic           sub_q;
    logic [W-1:0]   sum;
    logic [W-1:0]   data_q;

    // Search begins one past the previous winner and wraps at NREQ-1.
    always_comb begin : rr_pick
        int idx;
        found = 1'b0;
        win   = last_ptr;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign a_sel = req_a[int'(win)*W +: W];
    assign b_sel = req_b[int'(win)*W +: W];

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        req_ready = '0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                // Nothing is granted while reset is held, even though the
                // register already reads IDLE.
                if (rst_n && found) begin
                    grant          = 1'b1;
                    req_ready[win] = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_ptr <= IDW'(NREQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state <= state_d;
            if (grant) begin
                a_q      <= a_sel;
                b_q      <= b_sel;
                sub_q    <= req_sub[win];
                id_q     <= win;
                last_ptr <= win;
            end
            if (state == EXEC) begin
                data_q <= sum;
            end
        end
    end

    cla28 #(.WIDTH(WIDTH)) u_cla (
        .a   (a_q),
        .b   (b_q),
        .sub (sub_q),
        .sum (sum)
    );

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state != IDLE);

endmodule
